whistle_command_sequencer: RTL and testbench

Converts raw whistle-detection pulses from the FFT pitch detector into discrete whistle-count commands for downstream control logic. It sits in the `CLOCK_50` domain after the detector and replaces the LED pulse stretcher as the detector's consumer. It synchronises the detector output and debounces each whistle with a hold-off timer. It groups whistles that fall within an inter-whistle window and emits one command per group (1..MAX_COUNT whistles) over a valid/ready handshake.

---
 rtl/whistle_command_sequencer.sv | 159 +++++++++++++++
 tb/tb_whistle_command_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/whistle_command_sequencer.sv
// Turns raw whistle detector pulses into one counted command per group of whistles.
// Synchronises and edge-detects the detector output, debounces with a hold-off, groups by window.
module whistle_command_sequencer #(
    parameter int unsigned HOLDOFF_CYCLES = 10_000_000,
    parameter int unsigned WINDOW_CYCLES  = 50_000_000,
    parameter int unsigned MAX_COUNT      = 4,
    parameter int unsigned CNT_W          = $clog2(MAX_COUNT + 1)
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             enable,
    input  logic             whistle_in,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [CNT_W-1:0] cmd_count,
    output logic             cmd_sat,
    output logic             busy,
    output logic [7:0]       drop_count
);

    localparam int unsigned TimerMax = (HOLDOFF_CYCLES > WINDOW_CYCLES) ?
                                       HOLDOFF_CYCLES : WINDOW_CYCLES;
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);

    localparam logic [TimerW-1:0] HoldLoad   = TimerW'(HOLDOFF_CYCLES - 1);
    localparam logic [TimerW-1:0] WindowLoad = TimerW'(WINDOW_CYCLES - 1);
    localparam logic [TimerW-1:0] TimerOne   = TimerW'(1);
    localparam logic [CNT_W-1:0]  CountMax   = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0]  CountOne   = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StHoldoff,
        StWait,
        StEmit
    } state_e;

    logic sync1_q, sync2_q, sync3_q;
    logic whistle_event;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              sat_q, sat_d;
    logic [CNT_W-1:0]  cmd_count_q, cmd_count_d;
    logic              cmd_sat_q, cmd_sat_d;
    logic [7:0]        drop_q, drop_d;
    logic              valid_q;
    logic              busy_q;

    // whistle_in is asynchronous; s3 only serves the rising-edge detect.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= whistle_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign whistle_event = sync2_q & ~sync3_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        count_d     = count_q;
        sat_d       = sat_q;
        cmd_count_d = cmd_count_q;
        cmd_sat_d   = cmd_sat_q;
        drop_d      = drop_q;

        unique case (state_q)
            StIdle: begin
                if (whistle_event && enable) begin
                    count_d = CountOne;
                    sat_d   = 1'b0;
                    timer_d = HoldLoad;
                    state_d = StHoldoff;
                end
            end
            StHoldoff: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (timer_q == '0) begin
                    timer_d = WindowLoad;
                    state_d = StWait;
                end else begin
                    timer_d = timer_q - TimerOne;
                end
            end
            StWait: begin
                // A whistle arriving on the last window cycle still extends the group.
                if (!enable) begin
                    state_d = StIdle;
                end else if (whistle_event) begin
                    if (count_q >= CountMax - CountOne) begin
                        count_d = CountMax;
                        sat_d   = 1'b1;
                    end else begin
                        count_d = count_q + CountOne;
                    end
                    timer_d = HoldLoad;
                    state_d = StHoldoff;
                end else if (timer_q == '0) begin
                    cmd_count_d = count_q;
                    cmd_sat_d   = sat_q;
                    state_d     = StEmit;
                end else begin
                    timer_d = timer_q - TimerOne;
                end
            end
            StEmit: begin
                if (valid_q && cmd_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Whistles while a command is pending are lost, including on the transfer cycle.
        if (state_q == StEmit && whistle_event && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            count_q     <= '0;
            sat_q       <= 1'b0;
            cmd_count_q <= '0;
            cmd_sat_q   <= 1'b0;
            drop_q      <= 8'd0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            count_q     <= count_d;
            sat_q       <= sat_d;
            cmd_count_q <= cmd_count_d;
            cmd_sat_q   <= cmd_sat_d;
            drop_q      <= drop_d;
            valid_q     <= (state_d == StEmit);
            busy_q      <= (state_d != StIdle);
        end
    end

    assign cmd_valid  = valid_q;
    assign cmd_count  = cmd_count_q;
    assign cmd_sat    = cmd_sat_q;
    assign busy       = busy_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_whistle_command_sequencer.sv
// Directed bench for whistle_command_sequencer with short hold-off and window timers.
module tb_whistle_command_sequencer;

    localparam int unsigned H  = 4;
    localparam int unsigned W  = 10;
    localparam int unsigned M  = 4;
    localparam int unsigned CW = $clog2(M + 1);

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          whistle_in = 1'b0;
    logic          cmd_ready = 1'b1;
    logic          cmd_valid;
    logic [CW-1:0] cmd_count;
    logic          cmd_sat;
    logic          busy;
    logic [7:0]    drop_count;

    int checks = 0;
    int errors = 0;

    whistle_command_sequencer #(
        .HOLDOFF_CYCLES(H),
        .WINDOW_CYCLES (W),
        .MAX_COUNT     (M),
        .CNT_W         (CW)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .enable    (enable),
        .whistle_in(whistle_in),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_count (cmd_count),
        .cmd_sat   (cmd_sat),
        .busy      (busy),
        .drop_count(drop_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic logic [127:0] make_mask(input int n, input int sp, input int len);
        logic [127:0] m;
        m = '0;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < len; j++) begin
                m[k * sp + j] = 1'b1;
            end
        end
        return m;
    endfunction

    // Drives whistle_in from mask for a fixed number of cycles and records what was emitted.
    task automatic run_pattern(input logic [127:0] mask, input int cycles,
                               output int high_cycles, output int busy_c, output int valid_c,
                               output logic [CW-1:0] cnt, output logic sat_o);
        high_cycles = 0;
        busy_c      = -1;
        valid_c     = -1;
        cnt         = '0;
        sat_o       = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            whistle_in = mask[c];
            tick();
            if (busy && busy_c < 0) busy_c = c;
            if (cmd_valid) begin
                high_cycles++;
                if (valid_c < 0) begin
                    valid_c = c;
                    cnt     = cmd_count;
                    sat_o   = cmd_sat;
                end
            end
        end
        whistle_in = 1'b0;
    endtask

    initial begin
        int            hi, bc, vc;
        logic [CW-1:0] cnt;
        logic          sat;
        logic [127:0]  mask;

        tick();
        tick();
        check_eq("reset_valid", cmd_valid, 0);
        check_eq("reset_count", cmd_count, 0);
        check_eq("reset_sat", cmd_sat, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_drop", drop_count, 0);
        reset = 1'b0;
        tick();

        // Single whistle, 3 cycles high.
        mask = make_mask(1, 8, 3);
        run_pattern(mask, 40, hi, bc, vc, cnt, sat);
        check_eq("single_busy_lat", bc, 2);
        check_eq("single_valid_lat", vc, 16);
        check_eq("single_valid_len", hi, 1);
        check_eq("single_count", cnt, 1);
        check_eq("single_sat", sat, 0);
        check_eq("single_idle", busy, 0);

        // Three whistles 8 cycles apart.
        mask = make_mask(3, 8, 3);
        run_pattern(mask, 70, hi, bc, vc, cnt, sat);
        check_eq("three_valid_lat", vc, 32);
        check_eq("three_valid_len", hi, 1);
        check_eq("three_count", cnt, 3);
        check_eq("three_sat", sat, 0);

        // Second rising edge 2 cycles after the first lands in hold-off.
        mask = 128'b1101;
        run_pattern(mask, 40, hi, bc, vc, cnt, sat);
        check_eq("holdoff_valid_lat", vc, 16);
        check_eq("holdoff_valid_len", hi, 1);
        check_eq("holdoff_count", cnt, 1);

        // Six whistles saturate the count.
        mask = make_mask(6, 8, 3);
        run_pattern(mask, 100, hi, bc, vc, cnt, sat);
        check_eq("sat_valid_lat", vc, 56);
        check_eq("sat_valid_len", hi, 1);
        check_eq("sat_count", cnt, 4);
        check_eq("sat_flag", sat, 1);

        // Backpressure with a whistle dropped during EMIT.
        cmd_ready = 1'b0;
        mask = make_mask(1, 8, 3);
        run_pattern(mask, 17, hi, bc, vc, cnt, sat);
        check_eq("bp_valid_lat", vc, 16);
        check_eq("bp_count", cnt, 1);
        for (int i = 0; i < 20; i++) begin
            whistle_in = (i >= 3 && i < 6);
            tick();
            check_eq("bp_valid_held", cmd_valid, 1);
            check_eq("bp_count_stable", cmd_count, 1);
            check_eq("bp_sat_stable", cmd_sat, 0);
        end
        whistle_in = 1'b0;
        check_eq("bp_drop", drop_count, 1);
        cmd_ready = 1'b1;
        tick();
        check_eq("bp_valid_fall", cmd_valid, 0);
        check_eq("bp_idle", busy, 0);
        check_eq("bp_count_kept", cmd_count, 1);

        // enable dropped while in WAIT aborts the group.
        mask = make_mask(1, 8, 3);
        run_pattern(mask, 8, hi, bc, vc, cnt, sat);
        check_eq("abort_busy_before", busy, 1);
        enable = 1'b0;
        tick();
        check_eq("abort_busy", busy, 0);
        check_eq("abort_valid", cmd_valid, 0);
        enable = 1'b1;
        run_pattern('0, 30, hi, bc, vc, cnt, sat);
        check_eq("abort_no_emit", hi, 0);
        check_eq("abort_stays_idle", bc, -1);

        // Asynchronous reset during HOLDOFF.
        mask = make_mask(1, 8, 3);
        run_pattern(mask, 5, hi, bc, vc, cnt, sat);
        check_eq("rst_busy_before", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_async_valid", cmd_valid, 0);
        check_eq("rst_async_count", cmd_count, 0);
        check_eq("rst_async_sat", cmd_sat, 0);
        check_eq("rst_async_busy", busy, 0);
        check_eq("rst_async_drop", drop_count, 0);
        tick();
        reset = 1'b0;
        tick();
        run_pattern(mask, 40, hi, bc, vc, cnt, sat);
        check_eq("rst_after_lat", vc, 16);
        check_eq("rst_after_count", cnt, 1);
        check_eq("rst_after_sat", sat, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
